// File: rtl/mem_dump_reader.sv
// mem_dump_reader: streams a block of big-endian 32-bit words read from a byte-wide memory
module mem_dump_reader #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [31:0]       word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              word_last
);
    typedef enum logic [2:0] {IDLE, READ, FLUSH, OUT, FIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [1:0]        byte_idx;
    logic [23:0]       shift;
    logic              capture;
    logic              misaligned;
    logic              accept;
    logic              handshake;

    assign misaligned  = base_addr[1:0] != 2'b00;
    assign accept      = state == IDLE && start && !misaligned;
    assign handshake   = state == OUT && word_ready;
    assign busy        = state == READ || state == FLUSH || state == OUT;
    assign done        = state == FIN;
    assign mem_rd_en   = state == READ;
    assign mem_rd_addr = mem_rd_en ? addr + ADDR_W'(byte_idx) : '0;
    assign word_valid  = state == OUT;

    // next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = misaligned ? IDLE : (word_count == '0 ? FIN : READ);
            READ:    if (byte_idx == 2'd3) state_nx = FLUSH;
            FLUSH:   state_nx = OUT;
            OUT:     if (word_ready) state_nx = remaining == CNT_W'(1) ? FIN : READ;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // block counters, byte assembly (data lands one cycle after its request) and output word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            capture   <= 1'b0;
            error     <= 1'b0;
            word_data <= '0;
            word_addr <= '0;
            word_last <= 1'b0;
        end else begin
            error   <= state == IDLE && start && misaligned;
            capture <= mem_rd_en;
            if (capture) shift <= {shift[15:0], mem_rd_data};
            if (accept) begin
                addr      <= base_addr;
                remaining <= word_count;
                byte_idx  <= '0;
            end
            if (state == READ) byte_idx <= byte_idx + 2'd1;
            if (state == FLUSH) begin
                word_data <= {shift, mem_rd_data};
                word_addr <= addr;
                word_last <= remaining == CNT_W'(1);
            end
            if (handshake) begin
                remaining <= remaining - CNT_W'(1);
                addr      <= addr + ADDR_W'(4);
            end
        end
    end
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: randomized self-checking bench against a byte-memory word model
module tb_mem_dump_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        word_ready = 1'b0;
    logic [31:0] base_addr = '0;
    logic [7:0]  word_count = '0;
    logic        busy, done, error, mem_rd_en, word_valid, word_last;
    logic [31:0] mem_rd_addr, word_data, word_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  mem [0:63];

    int checks = 0;
    int errors = 0;

    logic [31:0] q_data[$];
    logic [31:0] q_addr[$];
    logic        q_last[$];
    int          q_cyc[$];
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    int n_busy, n_done, done_cyc, n_err, err_cyc, first_valid, stall_bad, n_valid;

    always #5 clock = ~clock;

    mem_dump_reader #(.ADDR_W(32), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_addr(word_addr), .word_last(word_last)
    );

    // memory contents: a small preloaded array, an address hash everywhere else
    function automatic logic [7:0] mb(input logic [31:0] a);
        return a < 32'd64 ? mem[a[5:0]] : a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {mb(a), mb(a + 32'd1), mb(a + 32'd2), mb(a + 32'd3)};
    endfunction

    // one-cycle read latency; garbage when not reading
    always @(posedge clock) mem_rd_data <= mem_rd_en ? mb(mem_rd_addr) : 8'($urandom);

    // issue one command and record everything the DUT does, cycle c spans edges E(c-1)..E(c)
    task automatic run_block(input logic [31:0] base, input logic [7:0] cnt, input int mode,
                             input int budget, input int inj);
        logic held_v;
        logic [31:0] hd, ha;
        logic hl;
        held_v = 1'b0;
        hd = '0;
        ha = '0;
        hl = 1'b0;
        q_data.delete(); q_addr.delete(); q_last.delete(); q_cyc.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        n_busy = 0; n_done = 0; done_cyc = -1; n_err = 0; err_cyc = -1;
        first_valid = -1; stall_bad = 0; n_valid = 0;
        @(negedge clock);
        start = 1'b1;
        base_addr = base;
        word_count = cnt;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);
            start = inj > 0 && (c == inj || c == inj + 6);
            if (start) begin
                base_addr = 32'h40;
                word_count = 8'd5;
            end
            word_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            if (held_v && !(word_valid && word_data == hd && word_addr == ha && word_last == hl)) stall_bad++;
            held_v = word_valid && !word_ready;
            hd = word_data;
            ha = word_addr;
            hl = word_last;
            if (mem_rd_en) begin
                rd_addr_q.push_back(mem_rd_addr);
                rd_cyc_q.push_back(c);
            end
            if (busy) n_busy++;
            if (error) begin
                n_err++;
                err_cyc = c;
            end
            if (word_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = c;
            end
            if (word_valid && word_ready) begin
                q_data.push_back(word_data);
                q_addr.push_back(word_addr);
                q_last.push_back(word_last);
                q_cyc.push_back(c);
            end
            if (done) begin
                n_done++;
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        word_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, error, mem_rd_en, word_valid, word_last} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000", {busy, done, error, mem_rd_en, word_valid, word_last});
        end
        checks++;
        if ({mem_rd_addr, word_data, word_addr} !== 96'b0) begin
            errors++;
            $display("FAIL reset_buses got %h exp 0", {mem_rd_addr, word_data, word_addr});
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_single;
        run_block(32'h4, 8'd1, 0, 40, -1);
        checks++;
        if (rd_addr_q.size() != 4) begin
            errors++;
            $display("FAIL single_nreads got %0d exp 4", rd_addr_q.size());
        end
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
            checks++;
            if (rd_addr_q[i] !== 32'(4 + i) || rd_cyc_q[i] != i + 1) begin
                errors++;
                $display("FAIL single_rd%0d got %h@%0d exp %h@%0d", i, rd_addr_q[i], rd_cyc_q[i], 4 + i, i + 1);
            end
        end
        checks++;
        if (first_valid != 6) begin
            errors++;
            $display("FAIL single_latency got %0d exp 6", first_valid);
        end
        checks++;
        if (q_data.size() != 1 || q_data[0] !== 32'h06400A13 || q_addr[0] !== 32'h4 || q_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_word got n=%0d %h/%h/%b exp 1 06400a13/00000004/1", q_data.size(), q_data[0], q_addr[0], q_last[0]);
        end
        checks++;
        if (n_done != 1 || q_cyc.size() != 1 || done_cyc != q_cyc[0] + 1) begin
            errors++;
            $display("FAIL single_done got n=%0d cyc=%0d exp 1 cyc=7", n_done, done_cyc);
        end
        checks++;
        if (n_busy != 6) begin
            errors++;
            $display("FAIL single_busy got %0d exp 6", n_busy);
        end
    endtask

    task automatic test_stream;
        run_block(32'h0, 8'd14, 0, 200, -1);
        checks++;
        if (q_data.size() != 14 || rd_addr_q.size() != 56 || n_done != 1) begin
            errors++;
            $display("FAIL stream_counts got words=%0d reads=%0d done=%0d exp 14 56 1", q_data.size(), rd_addr_q.size(), n_done);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== ref_word(32'(4 * i)) || q_addr[i] !== 32'(4 * i) || q_last[i] !== (i == 13)) begin
                errors++;
                $display("FAIL stream_w%0d got %h/%h/%b exp %h/%h/%b", i, q_data[i], q_addr[i], q_last[i], ref_word(32'(4 * i)), 4 * i, i == 13);
            end
        end
        checks++;
        if (q_data[6] !== 32'h017787B3 || q_data[13] !== 32'hFE9FF56F) begin
            errors++;
            $display("FAIL stream_known got %h %h exp 017787b3 fe9ff56f", q_data[6], q_data[13]);
        end
        checks++;
        if (q_cyc.size() != 14 || q_cyc[13] != 84) begin
            errors++;
            $display("FAIL stream_time got %0d exp 84", q_cyc[13]);
        end
    endtask

    task automatic test_stall;
        run_block(32'h0, 8'd14, 1, 400, -1);
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL stall_stable got %0d unstable cycles exp 0", stall_bad);
        end
        checks++;
        if (rd_addr_q.size() != 56 || q_data.size() != 14 || n_done != 1) begin
            errors++;
            $display("FAIL stall_counts got reads=%0d words=%0d done=%0d exp 56 14 1", rd_addr_q.size(), q_data.size(), n_done);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== ref_word(32'(4 * i)) || q_last[i] !== (i == 13)) begin
                errors++;
                $display("FAIL stall_w%0d got %h/%b exp %h/%b", i, q_data[i], q_last[i], ref_word(32'(4 * i)), i == 13);
            end
        end
    endtask

    task automatic test_misaligned_zero;
        run_block(32'h1A, 8'd2, 0, 10, -1);
        checks++;
        if (n_err != 1 || err_cyc != 1) begin
            errors++;
            $display("FAIL misaligned_error got n=%0d cyc=%0d exp 1 1", n_err, err_cyc);
        end
        checks++;
        if (rd_addr_q.size() != 0 || n_busy != 0 || n_valid != 0 || n_done != 0) begin
            errors++;
            $display("FAIL misaligned_quiet got reads=%0d busy=%0d valid=%0d done=%0d exp 0 0 0 0", rd_addr_q.size(), n_busy, n_valid, n_done);
        end
        run_block(32'h8, 8'd0, 0, 10, -1);
        checks++;
        if (n_done != 1 || done_cyc != 1) begin
            errors++;
            $display("FAIL zero_done got n=%0d cyc=%0d exp 1 1", n_done, done_cyc);
        end
        checks++;
        if (rd_addr_q.size() != 0 || n_valid != 0 || n_busy != 0 || n_err != 0) begin
            errors++;
            $display("FAIL zero_quiet got reads=%0d valid=%0d busy=%0d err=%0d exp 0 0 0 0", rd_addr_q.size(), n_valid, n_busy, n_err);
        end
    endtask

    task automatic test_wrap;
        run_block(32'hFFFFFFFC, 8'd2, 0, 40, -1);
        checks++;
        if (q_data.size() != 2 || q_addr[0] !== 32'hFFFFFFFC || q_addr[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr got n=%0d %h %h exp 2 fffffffc 00000000", q_data.size(), q_addr[0], q_addr[1]);
        end
        checks++;
        if (q_data[0] !== ref_word(32'hFFFFFFFC) || q_data[1] !== ref_word(32'h0) || rd_addr_q[4] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_data got %h %h exp %h %h", q_data[0], q_data[1], ref_word(32'hFFFFFFFC), ref_word(32'h0));
        end
    endtask

    task automatic test_busy_start;
        run_block(32'h10, 8'd3, 0, 60, 3);
        checks++;
        if (q_data.size() != 3 || n_done != 1 || done_cyc != 19) begin
            errors++;
            $display("FAIL busy_start_len got words=%0d done=%0d@%0d exp 3 1@19", q_data.size(), n_done, done_cyc);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== ref_word(32'(16 + 4 * i)) || q_addr[i] !== 32'(16 + 4 * i)) begin
                errors++;
                $display("FAIL busy_start_w%0d got %h/%h exp %h/%h", i, q_data[i], q_addr[i], ref_word(32'(16 + 4 * i)), 16 + 4 * i);
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] b;
            int n;
            int bad;
            b = $urandom_range(0, 1) ? 32'hFFFFFFF0 + 32'(4 * $urandom_range(0, 3)) : {$urandom, 2'b00};
            n = $urandom_range(1, 6);
            bad = 0;
            run_block(b, 8'(n), 2, 400, -1);
            for (int i = 0; i < n; i++) begin
                logic [31:0] a;
                a = b + 32'(4 * i);
                if (i >= q_data.size() || q_data[i] !== ref_word(a) || q_addr[i] !== a || q_last[i] !== (i == n - 1)) bad++;
            end
            checks++;
            if (bad != 0 || q_data.size() != n || n_done != 1 || stall_bad != 0 || rd_addr_q.size() != 4 * n) begin
                errors++;
                $display("FAIL random%0d base=%h n=%0d got words=%0d bad=%0d done=%0d unstable=%0d reads=%0d", k, b, n, q_data.size(), bad, n_done, stall_bad, rd_addr_q.size());
            end
        end
    endtask

    task automatic test_max_count;
        int lasts;
        run_block(32'h100, 8'd255, 0, 1600, -1);
        lasts = 0;
        foreach (q_last[i]) if (q_last[i]) lasts++;
        checks++;
        if (q_data.size() != 255 || n_done != 1 || lasts != 1 || q_last[254] !== 1'b1) begin
            errors++;
            $display("FAIL max_count got words=%0d done=%0d lasts=%0d exp 255 1 1", q_data.size(), n_done, lasts);
        end
        checks++;
        if (q_data[254] !== ref_word(32'h100 + 32'd1016) || q_cyc[254] != 1530) begin
            errors++;
            $display("FAIL max_tail got %h@%0d exp %h@1530", q_data[254], q_cyc[254], ref_word(32'h100 + 32'd1016));
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        start = 1'b1;
        base_addr = 32'h10;
        word_count = 8'd3;
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, mem_rd_en, word_valid, word_last, mem_rd_addr, word_data, word_addr} !== 102'b0) begin
            errors++;
            $display("FAIL reset_mid got en=%b busy=%b addr=%h data=%h", mem_rd_en, busy, mem_rd_addr, word_data);
        end
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, mem_rd_en, word_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_hold got %b exp 0000", {busy, done, mem_rd_en, word_valid});
        end
        reset = 1'b1;
        run_block(32'h4, 8'd1, 0, 40, -1);
        checks++;
        if (q_data.size() != 1 || q_data[0] !== 32'h06400A13 || n_done != 1) begin
            errors++;
            $display("FAIL reset_restart got n=%0d %h exp 1 06400a13", q_data.size(), q_data[0]);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'($urandom);
        {mem[4], mem[5], mem[6], mem[7]} = 32'h06400A13;
        {mem[24], mem[25], mem[26], mem[27]} = 32'h017787B3;
        {mem[52], mem[53], mem[54], mem[55]} = 32'hFE9FF56F;
        test_reset;
        test_single;
        test_stream;
        test_stall;
        test_misaligned_zero;
        test_wrap;
        test_busy_start;
        test_random;
        test_max_count;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
